// File: rtl/mem_loader_pkg.sv
// Shared types and frame-format constants for the boot-time program loader.
package mem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_WRITE,
        S_FINISH
    } loader_state_t;

    localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;
    localparam int         LEN_BYTES     = 4;
    localparam int         WORD_BYTES    = 4;

    // Bytes arrive least-significant first, so each new byte enters at the top.
    function automatic logic [31:0] le_shift(input logic [31:0] acc, input logic [7:0] b);
        return {b, acc[31:8]};
    endfunction

endpackage

// File: rtl/mem_loader.sv
// Parses a MAGIC/count/payload byte stream from the UART and writes the payload
// words into RAM over the PicoRV32 native memory interface, holding the CPU meanwhile.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 256,
    parameter logic [7:0]  MAGIC     = MAGIC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    loader_state_t state_q, state_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [1:0]    byte_q, byte_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          err_q, err_d;
    logic          take;
    logic          last_byte;

    assign take      = rx_valid && rx_ready;
    assign last_byte = (byte_q == 2'(LEN_BYTES - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (take && rx_data == MAGIC) begin
                    state_d = S_LEN;
                    byte_d  = 2'd0;
                    addr_d  = BASE_ADDR;
                end
            end
            S_LEN: begin
                if (take) begin
                    cnt_d  = le_shift(cnt_q, rx_data);
                    byte_d = byte_q + 2'd1;
                    if (last_byte) begin
                        if (cnt_d == 32'd0) begin
                            state_d = S_FINISH;
                        end else if (cnt_d > MAX_WORDS) begin
                            err_d   = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
            end
            S_DATA: begin
                if (take) begin
                    wdata_d = le_shift(wdata_q, rx_data);
                    byte_d  = byte_q + 2'd1;
                    if (last_byte) state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (mem_ready) begin
                    addr_d  = addr_q + 32'd4;
                    cnt_d   = cnt_q - 32'd1;
                    state_d = (cnt_q == 32'd1) ? S_FINISH : S_DATA;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            byte_q  <= '0;
            addr_q  <= BASE_ADDR;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    // Every output is a pure decode of registered state.
    assign rx_ready  = (state_q == S_IDLE) || (state_q == S_LEN) || (state_q == S_DATA);
    assign mem_valid = (state_q == S_WRITE);
    assign mem_wstrb = mem_valid ? 4'b1111 : 4'b0000;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_hold  = (state_q != S_IDLE);
    assign done      = (state_q == S_FINISH);
    assign error     = err_q;

endmodule

// File: tb/tb_mem_loader.sv
// Randomized scoreboard bench for mem_loader: frames are modelled as lists of
// expected writes plus a terminal done/error event; a monitor checks the bus.
module tb_mem_loader;
    import mem_loader_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int unsigned MAXW = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        cpu_hold;
    logic        done;
    logic        error;

    mem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW), .MAGIC(8'hA5)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         wq[$];       // expected writes, in order
    int          eq[$];       // expected terminal events: 1 = done, 2 = error
    logic [7:0]  garb_q[$];
    logic [31:0] words_q[$];
    int          tests = 0;
    int          fails = 0;
    bit          hold_ready = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) chk("rx_ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        if ($urandom_range(0, 3) == 0) begin
            rx_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((eq.size() != 0 || cpu_hold) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk("frame_timeout", 32'd1, 32'd0);
        chk("writes_left", wq.size(), 32'd0);
        wq.delete();
        eq.delete();
    endtask

    // Reference model: a legal frame of N words writes word i at BASE+4i, then done.
    task automatic send_frame(input logic [31:0] count);
        bit ok;
        ok = (count <= MAXW);
        if (ok) begin
            while (words_q.size() < int'(count)) words_q.push_back($urandom);
            for (int i = 0; i < int'(count); i++)
                wq.push_back('{addr: BASE + 32'(4 * i), data: words_q[i]});
            eq.push_back(1);
        end else begin
            eq.push_back(2);
        end
        foreach (garb_q[i]) send_byte(garb_q[i]);
        send_byte(8'hA5);
        send_word(count);
        if (ok) for (int i = 0; i < int'(count); i++) send_word(words_q[i]);
        rx_valid = 1'b0;
        garb_q.delete();
        words_q.delete();
        wait_idle();
    endtask

    // ---------------- monitor / scoreboard ----------------
    int          ncyc = 0, last_evt = 0, last_acc = 0, wait_ctr = 0;
    bit          pv = 0, pstall = 0, phs = 0, hold_fall_chk = 0;
    logic [31:0] pa, pd;
    wr_t         e;

    always begin
        @(negedge clk);
        #1;
        ncyc++;
        if (reset) begin
            pv = 0; pstall = 0; phs = 0; hold_fall_chk = 0;
            mem_ready = 1'b0;
        end else begin
            if (mem_valid) begin
                if (!pv) wait_ctr = ($urandom_range(0, 3) == 0) ? 3 : int'($urandom_range(0, 1));
                mem_ready = !hold_ready && (wait_ctr == 0);
                if (wait_ctr > 0) wait_ctr--;
            end else begin
                mem_ready = $urandom_range(0, 1) == 1;
            end
            #1;
            chk("wstrb", {28'd0, mem_wstrb}, mem_valid ? 32'hF : 32'h0);
            if (mem_valid) chk("rx_ready_in_write", rx_ready, 1'b0);
            if (pstall) begin
                chk("valid_held", mem_valid, 1'b1);
                chk("addr_stable", mem_addr, pa);
                chk("data_stable", mem_wdata, pd);
            end
            if (phs) chk("valid_gap", mem_valid, 1'b0);
            if (mem_valid && !pv) chk("valid_latency", ncyc, last_acc + 1);
            if (mem_valid && mem_ready) begin
                if (wq.size() == 0) begin
                    chk("unexpected_write", mem_addr, 32'hFFFF_FFFF);
                end else begin
                    e = wq.pop_front();
                    chk("wr_addr", mem_addr, e.addr);
                    chk("wr_data", mem_wdata, e.data);
                end
                last_evt = ncyc;
            end
            if (rx_valid && rx_ready) begin
                last_acc = ncyc;
                last_evt = ncyc;
            end
            if (hold_fall_chk) chk("cpu_hold_fall", cpu_hold, 1'b0);
            hold_fall_chk = 0;
            if (done) begin
                chk("done_expected", (eq.size() > 0) ? eq[0] : 0, 32'd1);
                if (eq.size() > 0) void'(eq.pop_front());
                chk("writes_before_done", wq.size(), 32'd0);
                chk("done_timing", ncyc, last_evt + 1);
                chk("hold_at_done", cpu_hold, 1'b1);
                hold_fall_chk = 1;
            end
            if (error) begin
                chk("error_expected", (eq.size() > 0) ? eq[0] : 0, 32'd2);
                if (eq.size() > 0) void'(eq.pop_front());
                chk("error_timing", ncyc, last_acc + 1);
                chk("hold_at_error", cpu_hold, 1'b0);
            end
            pstall = mem_valid && !mem_ready;
            phs    = mem_valid && mem_ready;
            pv     = mem_valid;
            pa     = mem_addr;
            pd     = mem_wdata;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        logic [7:0] g;
        logic [31:0] c;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_rx_ready", rx_ready, 1'b1);
        chk("rst_mem_valid", mem_valid, 1'b0);
        chk("rst_wstrb", {28'd0, mem_wstrb}, 32'h0);
        chk("rst_cpu_hold", cpu_hold, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_addr", mem_addr, BASE);
        chk("rst_wdata", mem_wdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Reference program with leading garbage.
        garb_q  = '{8'h00, 8'hFF, 8'h12};
        words_q = '{32'h00A0_0513, 32'h00B5_05B3};
        send_frame(32'd2);
        // Oversized and extreme counts are rejected; zero count finishes at once.
        send_frame(32'h0000_0101);
        send_frame(32'd0);
        send_frame(32'hFFFF_FFFF);
        send_frame(32'h0100_0000);
        // MAGIC bytes inside the payload are plain data.
        words_q = '{32'hA5A5_A5A5, 32'h0000_00A5};
        send_frame(32'd2);

        // Reset while a write is pending.
        @(negedge clk);
        hold_ready = 1'b1;
        send_byte(8'hA5);
        send_word(32'd3);
        send_word(32'hDEAD_BEEF);
        rx_valid = 1'b0;
        n = 0;
        while (!mem_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("pre_reset_valid", mem_valid, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #2;
        chk("reset_drops_valid", mem_valid, 1'b0);
        chk("reset_drops_hold", cpu_hold, 1'b0);
        chk("reset_addr", mem_addr, BASE);
        hold_ready = 1'b0;
        wq.delete();
        eq.delete();
        @(negedge clk);
        send_frame(32'd3);

        // Random frames.
        for (int f = 0; f < 20; f++) begin
            n = $urandom_range(0, 3);
            for (int i = 0; i < n; i++) begin
                do g = 8'($urandom_range(0, 255)); while (g == 8'hA5);
                garb_q.push_back(g);
            end
            c = ($urandom_range(0, 5) == 0) ? MAXW + 32'($urandom_range(1, 1000)) : 32'($urandom_range(0, 6));
            send_frame(c);
        end

        // Largest legal frame.
        send_frame(MAXW);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
